// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer:
// register offsets, FSM state encoding, MODE encoding and CTRL layout.
package timer_counter_pkg;

    // Register offsets, decoded from Addr[1:0] (byte address bits 3:2).
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // MODE field encodings. Encodings 2 and 3 fall back to one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Timer FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // CTRL register layout: bit3 IM, bits[2:1] MODE, bit0 EN.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // True when MODE selects auto-reload; every other encoding is one-shot.
    function automatic logic is_auto_reload(input logic [1:0] mode);
        return (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit memory-mapped down-counting timer. CTRL/PRESET/COUNT registers,
// a four-state FSM (IDLE, LOAD, CNT, INT), one-shot mode with a held
// interrupt and auto-reload mode with a one-cycle interrupt pulse.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [29:0]      Addr,
    input  logic             WE,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             IRQ
);

    state_t           state;
    state_t           state_next;
    ctrl_t            ctrl;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             pending;

    logic             wr_ctrl;
    logic             wr_preset;
    logic             load_count;
    logic             dec_count;
    logic             expire;
    logic             en_clr;
    logic             pend_clr_fsm;
    logic             unused_addr;

    // Only the two offset bits select a register; the rest is decoded upstream.
    assign unused_addr = ^Addr[29:2];

    assign wr_ctrl   = WE && (Addr[1:0] == REG_CTRL);
    assign wr_preset = WE && (Addr[1:0] == REG_PRESET);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-cycle datapath controls it issues.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        load_count   = 1'b0;
        dec_count    = 1'b0;
        expire       = 1'b0;
        en_clr       = 1'b0;
        pend_clr_fsm = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ctrl.en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load_count = 1'b1;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl.en) begin
                    state_next = ST_IDLE;
                end else if (count > WIDTH'(1)) begin
                    dec_count = 1'b1;
                end else begin
                    // Covers COUNT == 1 and COUNT == 0, so PRESET 0 acts as 1.
                    expire     = 1'b1;
                    state_next = ST_INT;
                end
            end
            ST_INT: begin
                state_next = ST_IDLE;
                if (is_auto_reload(ctrl.mode)) begin
                    pend_clr_fsm = 1'b1;
                end else begin
                    en_clr = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // CTRL register: a bus write overrides the one-shot EN clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= ctrl_t'(Din[3:0]);
        end else if (en_clr) begin
            ctrl.en <= 1'b0;
        end
    end

    // PRESET register: only sampled by LOAD, so mid-count writes wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= Din;
        end
    end

    // COUNT register: reload, decrement, or clamp to zero on expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load_count) begin
            count <= preset;
        end else if (dec_count) begin
            count <= count - WIDTH'(1);
        end else if (expire) begin
            count <= '0;
        end
    end

    // Interrupt pending bit: setting has priority over any clear source.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (expire) begin
            pending <= 1'b1;
        end else if (wr_ctrl || wr_preset || pend_clr_fsm) begin
            pending <= 1'b0;
        end
    end

    // Combinational read mux; offset 3 is unmapped and reads zero.
    always_comb begin
        Dout = '0;
        unique case (Addr[1:0])
            REG_CTRL:   Dout = {{(WIDTH-4){1'b0}}, ctrl};
            REG_PRESET: Dout = preset;
            REG_COUNT:  Dout = count;
            default:    Dout = '0;
        endcase
    end

    // Interrupt is a plain AND of two flops, so it cannot glitch.
    assign IRQ = pending & ctrl.im;

endmodule
